// File: rtl/tdc_core_pkg.sv
// Shared constants for the TDC event core: record field offsets, filter
// command encodings and the default global-counter width.
package tdc_core_pkg;

    localparam int GC_W_DEF  = 48;
    localparam int WORD_W    = 32;
    localparam int TDATA_W   = 128;

    localparam int TS_LSB    = 0;
    localparam int TS_W      = 48;
    localparam int STOP_LSB  = 64;
    localparam int STOP_W    = 28;
    localparam int IDX_LSB   = 92;
    localparam int IDX_W     = 4;
    localparam int CLICK_LSB = 96;
    localparam int CLICK_W   = 2;

    typedef enum logic [2:0] {
        CMD_ALL     = 3'd0,
        CMD_GATE0   = 3'd1,
        CMD_GATE1   = 3'd2,
        CMD_EITHER  = 3'd3,
        CMD_ALL_ALT = 3'd4
    } cmd_e;

    // Codes 5..7 deliberately reject every record.
    function automatic logic cmd_pass(input logic [2:0] cmd, input logic [1:0] click);
        case (cmd)
            CMD_ALL, CMD_ALL_ALT: cmd_pass = 1'b1;
            CMD_GATE0:            cmd_pass = click[0];
            CMD_GATE1:            cmd_pass = click[1];
            CMD_EITHER:           cmd_pass = |click;
            default:              cmd_pass = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tdc_core_deser.sv
// Serial-word receiver: a rising frame edge starts a word whose first bit is
// the MSB; after i_len bits the right-aligned word is strobed for one cycle.
module tdc_core_deser
    import tdc_core_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic [5:0]        i_len,
    input  logic              i_frame,
    input  logic              i_sdi,
    output logic [WORD_W-1:0] o_data,
    output logic              o_valid
);

    logic              r_frame_q;
    logic              r_busy;
    logic [5:0]        r_cnt;
    logic [WORD_W-2:0] r_shift;
    logic [WORD_W-1:0] r_data;
    logic              r_valid;

    logic              w_start;
    logic              w_take;
    logic              w_done;
    logic [5:0]        w_cnt_nxt;
    logic [WORD_W-1:0] w_shift_nxt;

    // Frame edges seen while busy are ignored; the word runs to its length.
    assign w_start     = i_frame & ~r_frame_q;
    assign w_take      = i_enable & (r_busy | w_start);
    assign w_shift_nxt = r_busy ? {r_shift, i_sdi} : {{(WORD_W-1){1'b0}}, i_sdi};
    assign w_cnt_nxt   = (r_busy ? r_cnt : 6'd0) + 6'd1;
    assign w_done      = w_take & (w_cnt_nxt >= i_len);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_frame_q <= 1'b1;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_frame_q <= i_frame;
            r_valid   <= w_done;
            if (!i_enable) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else if (w_take) begin
                r_shift <= w_shift_nxt[WORD_W-2:0];
                if (w_done) begin
                    r_busy <= 1'b0;
                    r_cnt  <= '0;
                    r_data <= w_shift_nxt;
                end else begin
                    r_busy <= 1'b1;
                    r_cnt  <= w_cnt_nxt;
                end
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/tdc_core.sv
// TDC event core: deserializes TDC words, timestamps, gates, filters and emits
// 128-bit records on an AXI-Stream style port. Gate logic needs TDC_CORE_GATE_EN.
module tdc_core
    import tdc_core_pkg::*;
#(
    parameter int GC_W = GC_W_DEF
) (
    input  logic                lclk_i,
    input  logic                lrst_i,
    input  logic                sr_enable,
    input  logic [15:0]         sr_index_stop_bitwise_i,
    input  logic                frame_i,
    input  logic                sdi_i,
    input  logic                sr_start_gc_i,
    input  logic                gc_rst,
    input  logic [15:0]         sr_shift_tdc_time_i,
    input  logic [15:0]         sr_shift_gc_back_i,
    input  logic [31:0]         sr_gate0_i,
    input  logic [31:0]         sr_gate1_i,
    input  logic [2:0]          sr_command_i,
    input  logic                sr_command_count,
    output logic [TDATA_W-1:0]  m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [3:0]          m_axis_tuser,
    output logic [15:0]         sr_total_count_o,
    output logic [WORD_W-1:0]   debug_tdc_data,
    output logic                debug_tdc_valid,
    output logic [GC_W-1:0]     gc
);

    logic [2:0]         w_iw;
    logic [4:0]         w_sw;
    logic [5:0]         w_len;
    logic [WORD_W-1:0]  w_word;
    logic               w_word_valid;
    logic [WORD_W-1:0]  w_stop_mask;
    logic [WORD_W-1:0]  w_stop_adj;
    logic [WORD_W-1:0]  w_index;
    logic [1:0]         w_click;
    logic               w_pass;
    logic [GC_W-1:0]    w_ts;
    logic [TS_W-1:0]    w_ts48;
    logic [TDATA_W-1:0] w_rec;
    logic               w_fire;
    logic               w_free;
    logic               w_unused;

    logic [GC_W-1:0]    r_gc;
    logic               r_s1_valid;
    logic [GC_W-1:0]    r_s1_ts;
    logic [STOP_W-1:0]  r_s1_stop;
    logic [IDX_W-1:0]   r_s1_idx;
    logic [1:0]         r_s1_click;
    logic               r_tvalid;
    logic [TDATA_W-1:0] r_tdata;
    logic [3:0]         r_tuser;
    logic               r_win_q;
    logic [15:0]        r_count;
    logic [15:0]        r_total;

    assign w_iw  = sr_index_stop_bitwise_i[2:0];
    assign w_sw  = sr_index_stop_bitwise_i[12:8];
    assign w_len = {3'd0, w_iw} + {1'b0, w_sw};

    tdc_core_deser u_deser (
        .i_clk    (lclk_i),
        .i_rst    (lrst_i),
        .i_enable (sr_enable),
        .i_len    (w_len),
        .i_frame  (frame_i),
        .i_sdi    (sdi_i),
        .o_data   (w_word),
        .o_valid  (w_word_valid)
    );

    assign w_stop_mask = (32'd1 << w_sw) - 32'd1;
    assign w_stop_adj  = ((w_word & w_stop_mask) + {16'd0, sr_shift_tdc_time_i}) & w_stop_mask;
    assign w_index     = w_word >> w_sw;
    assign w_ts        = r_gc - GC_W'(sr_shift_gc_back_i);

`ifdef TDC_CORE_GATE_EN
    assign w_click[0] = (sr_gate0_i[15:0] <= w_stop_adj[15:0]) && (w_stop_adj[15:0] <= sr_gate0_i[31:16]);
    assign w_click[1] = (sr_gate1_i[15:0] <= w_stop_adj[15:0]) && (w_stop_adj[15:0] <= sr_gate1_i[31:16]);
    assign w_unused   = ^{sr_index_stop_bitwise_i[15:13], sr_index_stop_bitwise_i[7:3],
                          w_stop_adj[31:28], w_index[31:4]};
`else
    assign w_click  = 2'b11;
    assign w_unused = ^{sr_index_stop_bitwise_i[15:13], sr_index_stop_bitwise_i[7:3],
                        w_stop_adj[31:28], w_index[31:4], sr_gate0_i, sr_gate1_i};
`endif

    assign w_pass = cmd_pass(sr_command_i, w_click);

    always_ff @(posedge lclk_i or posedge lrst_i) begin
        if (lrst_i) begin
            r_gc <= '0;
        end else if (gc_rst) begin
            r_gc <= '0;
        end else if (sr_start_gc_i) begin
            r_gc <= r_gc + 1'b1;
        end
    end

    always_ff @(posedge lclk_i or posedge lrst_i) begin
        if (lrst_i) begin
            r_s1_valid <= 1'b0;
            r_s1_ts    <= '0;
            r_s1_stop  <= '0;
            r_s1_idx   <= '0;
            r_s1_click <= '0;
        end else begin
            r_s1_valid <= w_word_valid & w_pass;
            if (w_word_valid) begin
                r_s1_ts    <= w_ts;
                r_s1_stop  <= w_stop_adj[STOP_W-1:0];
                r_s1_idx   <= w_index[IDX_W-1:0];
                r_s1_click <= w_click;
            end
        end
    end

    generate
        if (GC_W >= TS_W) begin : g_ts_trunc
            assign w_ts48 = r_s1_ts[TS_W-1:0];
        end else begin : g_ts_ext
            assign w_ts48 = {{(TS_W-GC_W){1'b0}}, r_s1_ts};
        end
    endgenerate

    always_comb begin
        w_rec = '0;
        w_rec[TS_LSB +: TS_W]       = w_ts48;
        w_rec[STOP_LSB +: STOP_W]   = r_s1_stop;
        w_rec[IDX_LSB +: IDX_W]     = r_s1_idx;
        w_rec[CLICK_LSB +: CLICK_W] = r_s1_click;
    end

    // m_axis: a record transfers on a rising edge with tvalid and tready both
    // high; while tvalid is high and tready low, tdata/tuser/tvalid hold and
    // any newly arriving record is dropped.
    assign w_fire = r_tvalid & m_axis_tready;
    assign w_free = ~r_tvalid | m_axis_tready;

    always_ff @(posedge lclk_i or posedge lrst_i) begin
        if (lrst_i) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tuser  <= '0;
        end else if (r_s1_valid && w_free) begin
            r_tvalid <= 1'b1;
            r_tdata  <= w_rec;
            r_tuser  <= r_s1_idx;
        end else if (w_fire) begin
            r_tvalid <= 1'b0;
        end
    end

    // Count window: records transferred while high; the falling edge publishes.
    always_ff @(posedge lclk_i or posedge lrst_i) begin
        if (lrst_i) begin
            r_win_q <= 1'b0;
            r_count <= '0;
            r_total <= '0;
        end else begin
            r_win_q <= sr_command_count;
            if (r_win_q && !sr_command_count) begin
                r_total <= r_count;
                r_count <= '0;
            end else if (sr_command_count && w_fire && (r_count != 16'hFFFF)) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    assign m_axis_tdata     = r_tdata;
    assign m_axis_tvalid    = r_tvalid;
    assign m_axis_tuser     = r_tuser;
    assign sr_total_count_o = r_total;
    assign debug_tdc_data   = w_word;
    assign debug_tdc_valid  = w_word_valid;
    assign gc               = r_gc;

endmodule

// File: tb/tb_tdc_core.sv
// Bench for tdc_core: table of serial words with expected record fields plus
// hand sequences for stall, abort, count window and mid-word reset.
`timescale 1ns/1ps
module tb_tdc_core;

    localparam int GC_W = 48;

    logic          lclk_i = 1'b0;
    logic          lrst_i = 1'b1;
    logic          sr_enable = 1'b0;
    logic [15:0]   sr_index_stop_bitwise_i = '0;
    logic          frame_i = 1'b0;
    logic          sdi_i = 1'b0;
    logic          sr_start_gc_i = 1'b0;
    logic          gc_rst = 1'b0;
    logic [15:0]   sr_shift_tdc_time_i = '0;
    logic [15:0]   sr_shift_gc_back_i = '0;
    logic [31:0]   sr_gate0_i = '0;
    logic [31:0]   sr_gate1_i = '0;
    logic [2:0]    sr_command_i = '0;
    logic          sr_command_count = 1'b0;
    logic [127:0]  m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic [3:0]    m_axis_tuser;
    logic [15:0]   sr_total_count_o;
    logic [31:0]   debug_tdc_data;
    logic          debug_tdc_valid;
    logic [GC_W-1:0] gc;

    tdc_core #(.GC_W(GC_W)) dut (
        .lclk_i                  (lclk_i),
        .lrst_i                  (lrst_i),
        .sr_enable               (sr_enable),
        .sr_index_stop_bitwise_i (sr_index_stop_bitwise_i),
        .frame_i                 (frame_i),
        .sdi_i                   (sdi_i),
        .sr_start_gc_i           (sr_start_gc_i),
        .gc_rst                  (gc_rst),
        .sr_shift_tdc_time_i     (sr_shift_tdc_time_i),
        .sr_shift_gc_back_i      (sr_shift_gc_back_i),
        .sr_gate0_i              (sr_gate0_i),
        .sr_gate1_i              (sr_gate1_i),
        .sr_command_i            (sr_command_i),
        .sr_command_count        (sr_command_count),
        .m_axis_tdata            (m_axis_tdata),
        .m_axis_tvalid           (m_axis_tvalid),
        .m_axis_tready           (m_axis_tready),
        .m_axis_tuser            (m_axis_tuser),
        .sr_total_count_o        (sr_total_count_o),
        .debug_tdc_data          (debug_tdc_data),
        .debug_tdc_valid         (debug_tdc_valid),
        .gc                      (gc)
    );

    // ---------------- clock ----------------
    always #5 lclk_i = ~lclk_i;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int obs_dbg = 0;
    int obs_rec = 0;
    logic [31:0]  dbg_q[$];
    logic [131:0] exp_q[$];
    logic [31:0]  mon_dbg_e;
    logic [131:0] mon_rec_e;

    task automatic check(input string name, input logic [131:0] act, input logic [131:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [131:0] make_rec(input logic [47:0] ts, input logic [27:0] stop,
                                              input logic [3:0] idx, input logic [1:0] click);
        logic [131:0] r;
        r = '0;
        r[47:0]    = ts;
        r[91:64]   = stop;
        r[95:92]   = idx;
        r[97:96]   = click;
        r[131:128] = idx;
        return r;
    endfunction

    function automatic logic [1:0] model_click(input logic [1:0] gate_click);
`ifdef TDC_CORE_GATE_EN
        return gate_click;
`else
        return 2'b11;
`endif
    endfunction

    function automatic logic model_pass(input logic [2:0] cmd, input logic [1:0] click);
        case (cmd)
            3'd0, 3'd4: return 1'b1;
            3'd1:       return click[0];
            3'd2:       return click[1];
            3'd3:       return click[0] | click[1];
            default:    return 1'b0;
        endcase
    endfunction

    always @(negedge lclk_i) begin
        if (!lrst_i) begin
            if (debug_tdc_valid) begin
                obs_dbg++;
                if (dbg_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dbg_unexpected actual=%h required=none", debug_tdc_data);
                end else begin
                    mon_dbg_e = dbg_q.pop_front();
                    check("dbg_word", 132'(debug_tdc_data), 132'(mon_dbg_e));
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                obs_rec++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rec_unexpected actual=%h required=none", {m_axis_tuser, m_axis_tdata});
                end else begin
                    mon_rec_e = exp_q.pop_front();
                    check("record", {m_axis_tuser, m_axis_tdata}, mon_rec_e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge lclk_i);
        #1;
    endtask

    task automatic set_cfg(input logic [7:0] iw, input logic [7:0] sw, input logic [15:0] sh_t,
                           input logic [15:0] sh_b, input logic [31:0] g0, input logic [31:0] g1,
                           input logic [2:0] cmd);
        sr_index_stop_bitwise_i = {sw, iw};
        sr_shift_tdc_time_i     = sh_t;
        sr_shift_gc_back_i      = sh_b;
        sr_gate0_i              = g0;
        sr_gate1_i              = g1;
        sr_command_i            = cmd;
    endtask

    task automatic send_word(input logic [31:0] w, input int n, input int glitch_at, input int abort_at);
        cyc(1);
        frame_i   = 1'b0;
        sr_enable = 1'b1;
        for (int i = n - 1; i >= 0; i--) begin
            cyc(1);
            frame_i   = (i == glitch_at) ? 1'b0 : 1'b1;
            sdi_i     = w[i];
            sr_enable = (i == abort_at) ? 1'b0 : 1'b1;
        end
        cyc(1);
        frame_i   = 1'b0;
        sdi_i     = 1'b0;
        sr_enable = 1'b1;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((dbg_q.size() != 0 || exp_q.size() != 0) && t < 200) begin
            cyc(1);
            t++;
        end
        checks++;
        if (dbg_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d/%0d pending required=0/0", dbg_q.size(), exp_q.size());
            dbg_q.delete();
            exp_q.delete();
        end
        cyc(4);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] word;
        logic [7:0]  iw;
        logic [7:0]  sw;
        logic [15:0] sh_t;
        logic [15:0] sh_b;
        logic [31:0] g0;
        logic [31:0] g1;
        logic [2:0]  cmd;
        int          glitch;
        logic [3:0]  e_idx;
        logic [27:0] e_stop;
        logic [47:0] e_ts;
        logic [1:0]  e_click;
    } vec_t;

    vec_t vecs[8];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int n_before;
        int r_before;
        logic [1:0]  clk_m;
        logic [31:0] w;
        logic [131:0] r1;

        vecs[0] = '{32'h0002C005, 8'd4, 8'd14, 16'd0,     16'd10,   32'hFF000064, 32'h00100000, 3'd0, 9,  4'hB, 28'd5,       48'd990,           2'b10};
        vecs[1] = '{32'h0000FFFE, 8'd4, 8'd14, 16'd3,     16'd0,    32'hFF000064, 32'h00100000, 3'd2, -1, 4'h3, 28'd1,       48'd1000,          2'b10};
        vecs[2] = '{32'h00000064, 8'd0, 8'd16, 16'd0,     16'd2000, 32'hFF000064, 32'h00050010, 3'd1, -1, 4'h0, 28'd100,     48'hFFFFFFFFFC18,  2'b01};
        vecs[3] = '{32'h00000063, 8'd0, 8'd16, 16'd0,     16'd0,    32'hFF000064, 32'h00050010, 3'd1, -1, 4'h0, 28'd99,      48'd1000,          2'b00};
        vecs[4] = '{32'hF0000002, 8'd4, 8'd28, 16'hFFFF,  16'd0,    32'h00020001, 32'hFFFF0000, 3'd3, 15, 4'hF, 28'h0010001, 48'd1000,          2'b11};
        vecs[5] = '{32'h00000001, 8'd0, 8'd1,  16'd1,     16'd0,    32'h00000000, 32'h00000001, 3'd5, -1, 4'h0, 28'd0,       48'd1000,          2'b01};
        vecs[6] = '{32'h000003A5, 8'd2, 8'd8,  16'h0100,  16'd0,    32'h00A500A5, 32'h00A400A6, 3'd4, -1, 4'h3, 28'hA5,      48'd1000,          2'b01};
        vecs[7] = '{32'h0000001F, 8'd1, 8'd4,  16'd0,     16'd0,    32'h00010000, 32'h00010000, 3'd3, 2,  4'h1, 28'hF,       48'd1000,          2'b00};

        // reset state
        lrst_i = 1'b1;
        cyc(3);
        lrst_i = 1'b0;
        @(negedge lclk_i);
        check("rst_tvalid", 132'(m_axis_tvalid), 132'd0);
        check("rst_tdata", 132'(m_axis_tdata), 132'd0);
        check("rst_tuser", 132'(m_axis_tuser), 132'd0);
        check("rst_dbg_valid", 132'(debug_tdc_valid), 132'd0);
        check("rst_dbg_data", 132'(debug_tdc_data), 132'd0);
        check("rst_gc", 132'(gc), 132'd0);
        check("rst_total", 132'(sr_total_count_o), 132'd0);

        // global counter: clear wins over run, then run exactly 1000 cycles
        cyc(1);
        sr_start_gc_i = 1'b1;
        gc_rst        = 1'b1;
        cyc(3);
        @(negedge lclk_i);
        check("gc_clear_priority", 132'(gc), 132'd0);
        cyc(1);
        gc_rst = 1'b0;
        cyc(1000);
        sr_start_gc_i = 1'b0;
        @(negedge lclk_i);
        check("gc_run_1000", 132'(gc), 132'd1000);

        // table-driven words
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            set_cfg(vecs[k].iw, vecs[k].sw, vecs[k].sh_t, vecs[k].sh_b, vecs[k].g0, vecs[k].g1, vecs[k].cmd);
            cyc(1);
            dbg_q.push_back(vecs[k].word);
            clk_m = model_click(vecs[k].e_click);
            if (model_pass(vecs[k].cmd, clk_m))
                exp_q.push_back(make_rec(vecs[k].e_ts, vecs[k].e_stop, vecs[k].e_idx, clk_m));
            send_word(vecs[k].word, int'(vecs[k].iw) + int'(vecs[k].sw), vecs[k].glitch, -1);
            wait_drain();
        end

        // enable dropped mid-word: the word is abandoned
        set_cfg(8'd4, 8'd14, 16'd0, 16'd0, 32'hFFFF0000, 32'hFFFF0000, 3'd0);
        n_before = obs_dbg;
        send_word(32'h0002C005, 18, -1, 10);
        cyc(30);
        check("abort_no_word", 132'(obs_dbg), 132'(n_before));
        dbg_q.push_back(32'h0002C005);
        exp_q.push_back(make_rec(48'd1000, 28'd5, 4'hB, 2'b11));
        send_word(32'h0002C005, 18, -1, -1);
        wait_drain();

        // downstream stall: first record held, later ones dropped
        m_axis_tready = 1'b0;
        r1 = make_rec(48'd1000, 28'h11, 4'h5, 2'b11);
        dbg_q.push_back(32'h00014011);
        dbg_q.push_back(32'h00028022);
        dbg_q.push_back(32'h0003C033);
        exp_q.push_back(r1);
        r_before = obs_rec;
        send_word(32'h00014011, 18, -1, -1);
        send_word(32'h00028022, 18, -1, -1);
        @(negedge lclk_i);
        check("stall_tvalid_a", 132'(m_axis_tvalid), 132'd1);
        check("stall_hold_a", {m_axis_tuser, m_axis_tdata}, r1);
        send_word(32'h0003C033, 18, -1, -1);
        cyc(4);
        @(negedge lclk_i);
        check("stall_tvalid_b", 132'(m_axis_tvalid), 132'd1);
        check("stall_hold_b", {m_axis_tuser, m_axis_tdata}, r1);
        cyc(1);
        m_axis_tready = 1'b1;
        wait_drain();
        check("stall_delivered", 132'(obs_rec - r_before), 132'd1);

        // count window with five accepted records
        cyc(1);
        sr_command_count = 1'b1;
        for (int k = 0; k < 5; k++) begin
            w = 32'($urandom_range(0, 32'h3FFFF));
            dbg_q.push_back(w);
            exp_q.push_back(make_rec(48'd1000, {14'd0, w[13:0]}, w[17:14], 2'b11));
            send_word(w, 18, -1, -1);
            wait_drain();
        end
        sr_command_count = 1'b0;
        cyc(2);
        @(negedge lclk_i);
        check("count_five", 132'(sr_total_count_o), 132'd5);
        cyc(1);
        sr_command_count = 1'b1;
        cyc(3);
        sr_command_count = 1'b0;
        cyc(2);
        @(negedge lclk_i);
        check("count_empty_window", 132'(sr_total_count_o), 132'd0);

        // reset in the middle of a word, frame held high across release
        n_before = obs_dbg;
        r_before = obs_rec;
        cyc(1);
        frame_i = 1'b0;
        cyc(1);
        frame_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sdi_i = 1'($urandom_range(0, 1));
            cyc(1);
        end
        lrst_i = 1'b1;
        cyc(2);
        lrst_i = 1'b0;
        for (int k = 0; k < 12; k++) begin
            sdi_i = 1'($urandom_range(0, 1));
            cyc(1);
        end
        frame_i = 1'b0;
        cyc(30);
        @(negedge lclk_i);
        check("rst_mid_gc", 132'(gc), 132'd0);
        check("rst_mid_no_dbg", 132'(obs_dbg), 132'(n_before));
        check("rst_mid_no_rec", 132'(obs_rec), 132'(r_before));
        check("rst_mid_tvalid", 132'(m_axis_tvalid), 132'd0);

        // core still works after reset; gc is now 0
        cyc(1);
        dbg_q.push_back(32'h0002C005);
        exp_q.push_back(make_rec(48'd0, 28'd5, 4'hB, 2'b11));
        send_word(32'h0002C005, 18, -1, -1);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdc_core.md
TDC_CORE -- requirements
Module: tdc_core

Interface
REQ-001 SHALL have parameter GC_W, default 48, global-counter width.
REQ-002 SHALL have port lclk_i  in  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port lrst_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port sr_enable  in  1  capture enable; low discards serial words.
REQ-005 SHALL have port sr_index_stop_bitwise_i  in  16  [15:8] stop width S (1..28), [7:0] index width I (0..4).
REQ-006 SHALL have port frame_i  in  1  TDC serial frame strobe.
REQ-007 SHALL have port sdi_i  in  1  TDC serial data, MSB first.
REQ-008 SHALL have port sr_start_gc_i  in  1  global counter run enable.
REQ-009 SHALL have port gc_rst  in  1  synchronous global counter clear.
REQ-010 SHALL have port sr_shift_tdc_time_i  in  16  offset added to stop value.
REQ-011 SHALL have port sr_shift_gc_back_i  in  16  offset subtracted from timestamp.
REQ-012 SHALL have port sr_gate0_i  in  32  gate 0: [15:0] low bound, [31:16] high bound.
REQ-013 SHALL have port sr_gate1_i  in  32  gate 1, same format.
REQ-014 SHALL have port sr_command_i  in  3  output filter mode.
REQ-015 SHALL have port sr_command_count  in  1  event-count window.
REQ-016 SHALL have port m_axis_tdata  out  128  event record.
REQ-017 SHALL have port m_axis_tvalid  out  1  record valid.
REQ-018 SHALL have port m_axis_tready  in  1  downstream ready.
REQ-019 SHALL have port m_axis_tuser  out  4  index of record.
REQ-020 SHALL have port sr_total_count_o  out  16  last latched event count.
REQ-021 SHALL have port debug_tdc_data / debug_tdc_valid  out  32/1  raw deserialized word, 1-cycle strobe.
REQ-022 SHALL have port gc  out  GC_W  live global counter.

Function
REQ-023 SHALL start a word on the cycle frame_i is 1 and was 0 the previous cycle; sdi_i sampled that cycle is the MSB; word completes after I+S bits, then debug_tdc_valid pulses one cycle with word right-aligned, zero-extended.
REQ-024 SHALL ignore frame edges inside an incomplete word; sr_enable low SHALL abort the current word.
REQ-025 SHALL split word: index = upper I bits, stop = lower S bits; stop_adj = (stop + sr_shift_tdc_time_i) mod 2^S.
REQ-026 SHALL run gc += 1 per cycle while sr_start_gc_i=1; gc_rst clears to 0 (priority over increment); wraps at 2^GC_W; timestamp = gc captured at word completion minus sr_shift_gc_back_i, mod 2^GC_W.
REQ-027 SHALL set click_result[k] = 1 when gatek low <= stop_adj[15:0] <= gatek high (inclusive); low > high gives 0.
REQ-028 SHALL filter by sr_command_i: 0 all, 1 click[0], 2 click[1], 3 either, 4 all, 5-7 none.
REQ-029 SHALL pack tdata: [47:0] timestamp, [63:48] 0, [91:64] stop_adj, [95:92] index, [97:96] click_result, [127:98] 0; tuser = index; latency 2 cycles from debug_tdc_valid to tvalid.
REQ-030 SHALL hold tdata/tvalid stable until tready; a record arriving while one is pending SHALL be dropped.
REQ-031 SHALL count accepted records (16-bit, saturating at 0xFFFF) while sr_command_count=1; on its falling edge latch count into sr_total_count_o and clear counter.

Reset
REQ-032 SHALL clear on lrst_i: gc, shifter, counters, sr_total_count_o, tvalid, debug_tdc_valid, all data outputs to 0; reset mid-word discards the word.
REQ-033 SHALL accept no frame edge in the first cycle after reset release (previous-frame register resets to 1).

Configuration
REQ-034 SHALL, with TDC_CORE_GATE_EN defined, implement REQ-027; without it click_result=2'b11 constantly and gate ports are unused.

Structure
REQ-035 SHALL place field offsets, command encodings and GC_W default in package tdc_core_pkg.
REQ-036 SHALL implement deserializer as sub-module tdc_core_deser (REQ-023/024).

Verification
REQ-037 SHALL check I=4,S=14, serial word 0x2C005 -> debug_tdc_data=0x0002C005, index=0xB, stop=0x0005.
REQ-038 SHALL check gate0=0xFF000064, stop_adj=100 -> click[0]=1; stop_adj=99 -> click[0]=0, mode 1 drops it.
REQ-039 SHALL check gc=1000 at completion, shift_gc_back=10 -> tdata[47:0]=990; shift_tdc_time=3, stop=0x3FFE -> stop_adj=1.
REQ-040 SHALL check tready=0 for 3 words -> only first delivered, fields unchanged while stalled.
REQ-041 SHALL check 5 accepted records in count window -> sr_total_count_o=5 after window falls.
REQ-042 SHALL check lrst_i mid-word -> no valid output, gc=0.
